// File: rtl/mult_div_ctrl.sv
// Multicycle signed multiply/divide sequencer feeding the HI/LO result registers.
// Operand magnitudes are processed over WIDTH iterations, then signs are fixed up in a final cycle.
module mult_div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               op_r;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  always_comb begin
    abs_a     = a[WIDTH-1] ? -a : a;
    abs_b     = b[WIDTH-1] ? -b : b;
    // Shift-add: acc holds {partial product, remaining multiplier bits}.
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    // Restoring divide: quo shifts dividend bits out the top while quotient bits enter at the bottom.
    rem_shift = {rem, quo[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, mag_b};
    prod_fix  = (sign_a ^ sign_b) ? -acc : acc;
    q_fix     = (sign_a ^ sign_b) ? -quo : quo;
    r_fix     = sign_a ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_r     <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      quo      <= '0;
      rem      <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op && (b == '0)) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              op_r   <= op;
              sign_a <= a[WIDTH-1];
              sign_b <= b[WIDTH-1];
              mag_a  <= abs_a;
              mag_b  <= abs_b;
              acc    <= {{WIDTH{1'b0}}, abs_b};
              quo    <= abs_a;
              rem    <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          acc <= {add_sum, acc[WIDTH-1:1]};
          rem <= rem_ge ? WIDTH'(rem_shift - {1'b0, mag_b}) : rem_shift[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], rem_ge};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (op_r) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
Multicycle sequencer for the datapath's shared multiply/divide resource, driving the HI/LO result registers for mult/div instructions. The main control unit pulses start with the decoded op and the A/B register contents, waits on busy/done, and then moves HI/LO via the MemToReg path. It owns an iterative shift-add multiplier and a restoring divider, the operand sign handling, and divide-by-zero signalling that the control unit routes to its exception states.

Parameters:
WIDTH, 32, operand width; hi/lo are WIDTH bits each, product is 2*WIDTH.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
op  input  1  0 = signed multiply, 1 = signed divide.
a  input  WIDTH  multiplicand / dividend (two's complement).
b  input  WIDTH  multiplier / divisor (two's complement).
busy  output  1  high while state != IDLE.
done  output  1  one-cycle completion pulse (registered).
div_zero  output  1  one-cycle pulse: divide requested with b == 0.
hi  output  WIDTH  mult: product[2W-1:W]; div: remainder.
lo  output  WIDTH  mult: product[W-1:0]; div: quotient.

Behaviour:
- Reset: when reset is low at a rising edge, the block resets regardless of state, including mid-operation. It enters IDLE with busy=0, done=0, div_zero=0, hi=0, lo=0, and clears counter and internal registers.
- States: IDLE, CALC, FIX. All outputs are registered.
- IDLE, start=1, div-by-zero case (op=1, b==0):
  - Stay in IDLE.
  - Next cycle: done=1 and div_zero=1 for exactly one cycle.
  - hi/lo unchanged.
- IDLE, start=1, normal case:
  - Latch |a|, |b|, op, sign(a), sign(b) into internal registers.
  - Counter <= 0; go to CALC; busy=1 from the next cycle.
  - a/b/op changes after this edge have no effect.
- CALC: one iteration per cycle, 32 cycles (counter 0..31). At counter == WIDTH-1, go to FIX.
  - Multiply: shift-add on unsigned magnitudes into a 2W accumulator.
  - Divide: restoring step on unsigned magnitudes, producing a quotient bit and a partial remainder.
- FIX: apply sign correction, write hi/lo, pulse done for one cycle, go to IDLE (busy=0 in the same cycle done=1).
  - Multiply: negate the 2W product if sign(a) XOR sign(b).
  - Divide: negate the quotient if sign(a) XOR sign(b); negate the remainder if sign(a). Quotient truncates toward zero, so a = q*b + r.
- Latency: start sampled at edge E0. Edges E1..E32 run CALC. Edge E33 runs FIX. done/busy-drop/hi/lo update are visible after E33, i.e. 33 cycles after acceptance.
- start while busy: ignored, no queueing. start held high in the cycle done=1 (state IDLE) is accepted as a new operation.
- hi/lo change only at FIX completion or reset; they hold between operations.
- Wrap cases:
  - -2^31 / -1 gives lo=0x80000000, hi=0; no overflow flag.
  - -2^31 * -2^31 gives hi=0x40000000, lo=0.
- Magnitude of -2^31 is 0x80000000, treated as unsigned WIDTH bits. Internal arithmetic is WIDTH+1 bits where needed to avoid loss.

Test Plan:
- Multiply 7 × -3: op=0, a=7, b=0xFFFFFFFD, start 1 cycle → busy for 33 cycles; done at cycle 33 with hi=0xFFFFFFFF, lo=0xFFFFFFEB; div_zero=0.
- Divide -7 / 2: op=1, a=0xFFFFFFF9, b=2 → done at cycle 33 with lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Divide by zero: preload hi/lo via 5×6 (hi=0, lo=30), then op=1, a=9, b=0 → next cycle done=div_zero=1 for one cycle; busy stays 0; hi=0, lo=30 unchanged.
- Busy and start-back-to-back:
  - Start 0x80000000 / 0xFFFFFFFF; at cycle 10 pulse start with op=0, a=b=2 → ignored; done at cycle 33 with lo=0x80000000, hi=0.
  - Start high in the done cycle → new op accepted.
- Reset mid-operation: start 0x12345678 × 0x10, drive reset low at cycle 15 → next cycle busy=done=0, hi=lo=0. After reset release, 3×4 completes in 33 cycles with lo=12.
- Max-magnitude multiply: a=b=0x80000000 → hi=0x40000000, lo=0; also a=b=0xFFFFFFFF → hi=0, lo=1.
